ad7266_rx: RTL and testbench

- Upstream capture stage for the AD7266 dual 12-bit SAR ADC. Feeds data_trans_mux.
- Drives the ADC serial interface: CS_n, SCLK and channel address A2..A0. Captures DOUTA and DOUTB in parallel.
- Delivers one 16-bit zero-extended word per channel, with a one-cycle write strobe, at a fixed sample period.
- Runs entirely in the ADC-side clock domain: clk is the clock the mux sees as ad7266sdclk.

---
 rtl/ad7266_pkg.sv | 36 +++
 rtl/ad7266_rx_if.sv | 24 ++
 rtl/ad7266_sclk_gen.sv | 61 ++++++
 rtl/ad7266_rx.sv | 174 +++++++++++++++++
 tb/tb_ad7266_rx.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ad7266_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : ad7266_pkg                                                    |
// | Desc     : Shared types, frame geometry and helpers for the AD7266       |
// |            capture path.                                                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package ad7266_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2,
      QUIET = 2'd3
   } state_t;

   // 16 SCLK rises per frame: 2 leading zeros, 12-bit code, 2 trailing zeros
   localparam int FRAME_BITS = 16;
   localparam int DATA_MSB   = 13;
   localparam int DATA_LSB   = 2;
   localparam int ADC_BITS   = 12;
   localparam int OUT_W      = 16;
   localparam int EDGE_W     = 5;   // holds 0..FRAME_BITS

   // Zero-extend a 12-bit conversion code to the output word width
   function automatic logic [OUT_W-1:0] code_to_word(input logic [ADC_BITS-1:0] code);
      return {{(OUT_W-ADC_BITS){1'b0}}, code};
   endfunction

   // High when any of the four padding bits of a frame is set
   function automatic logic pad_nonzero(input logic [3:0] pad);
      return |pad;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ad7266_rx_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface: ad7266_rx_if                                                  |
// | Desc     : Sample bus from the AD7266 capture stage to the data mux.     |
// |            With AD7266_ZERO_CHECK_EN the bus also carries frame_err.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface ad7266_rx_if;
   import ad7266_pkg::*;

   logic [OUT_W-1:0] ad7266dataa;
   logic [OUT_W-1:0] ad7266datab;
   logic             ad7266wren;
`ifdef AD7266_ZERO_CHECK_EN
   logic             frame_err;

   modport master (output ad7266dataa, output ad7266datab, output ad7266wren, output frame_err);
   modport slave  (input  ad7266dataa, input  ad7266datab, input  ad7266wren, input  frame_err);
`else
   modport master (output ad7266dataa, output ad7266datab, output ad7266wren);
   modport slave  (input  ad7266dataa, input  ad7266datab, input  ad7266wren);
`endif
endinterface
`default_nettype wire

// File: rtl/ad7266_sclk_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ad7266_sclk_gen                                               |
// | Desc     : SCLK divider for the AD7266 frame. Toggles SCLK every         |
// |            CLK_DIV clks while run is high, flags each 0->1 transition    |
// |            and counts rising edges within the frame.                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ad7266_sclk_gen
   import ad7266_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic              clear,
   output logic              adc_sclk,
   output logic              rise_pulse,
   output logic [EDGE_W-1:0] edge_cnt
);

   localparam int               DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0]  r_div;
   logic              r_sclk;
   logic [EDGE_W-1:0] r_edge_cnt;
   logic              w_wrap;

   assign w_wrap     = run && (r_div == c_div_last);
   // A wrap while SCLK is low is the rising edge; the FSM samples data on it
   assign rise_pulse = w_wrap && !r_sclk;
   assign adc_sclk   = r_sclk;
   assign edge_cnt   = r_edge_cnt;

   // Divide counter, SCLK toggle and rising-edge count; SCLK parks high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div      <= '0;
         r_sclk     <= 1'b1;
         r_edge_cnt <= '0;
      end else if (clear) begin
         r_div      <= '0;
         r_sclk     <= 1'b1;
         r_edge_cnt <= '0;
      end else if (run) begin
         if (w_wrap) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
            if (!r_sclk) begin
               r_edge_cnt <= r_edge_cnt + 1'b1;
            end
         end else begin
            r_div <= r_div + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/ad7266_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ad7266_rx                                                     |
// | Desc     : AD7266 dual-channel capture. Runs CS_n/SCLK/address framing,  |
// |            shifts DOUTA/DOUTB in parallel and presents one zero-extended |
// |            word per channel with a single-cycle strobe per frame.        |
// | Options  : AD7266_ZERO_CHECK_EN - adds frame_err, set when any padding   |
// |            bit of either channel is nonzero.                             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ad7266_rx
   import ad7266_pkg::*;
#(
   parameter int CLK_DIV       = 2,
   parameter int QUIET_CYCLES  = 4,
   parameter int SAMPLE_PERIOD = 80
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [2:0]  chsel,
   input  logic        adc_douta,
   input  logic        adc_doutb,
   output logic        adc_cs_n,
   output logic        adc_sclk,
   output logic [2:0]  adc_addr,
   output logic        busy,
   ad7266_rx_if.master dout
);

   localparam int                PER_W       = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int                QUI_W       = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
   localparam logic [PER_W-1:0]  c_per_last  = PER_W'(SAMPLE_PERIOD - 1);
   localparam logic [QUI_W-1:0]  c_qui_last  = QUI_W'(QUIET_CYCLES - 1);
   localparam logic [EDGE_W-1:0] c_last_edge = EDGE_W'(FRAME_BITS - 1);

   state_t                r_state;
   logic                  r_cs_n;
   logic [2:0]            r_addr;
   logic                  r_busy;
   logic [PER_W-1:0]      r_period;
   logic [QUI_W-1:0]      r_quiet;
   logic [FRAME_BITS-1:0] r_sra;
   logic [FRAME_BITS-1:0] r_srb;
   logic [OUT_W-1:0]      r_dataa;
   logic [OUT_W-1:0]      r_datab;
   logic                  r_wren;

   logic                  w_run;
   logic                  w_clear;
   logic                  w_rise;
   logic [EDGE_W-1:0]     w_edge_cnt;
   logic                  w_period_done;
   logic                  w_quiet_done;

   assign w_run         = (r_state == SHIFT);
   assign w_clear       = (r_state == DONE);
   assign w_period_done = (r_period == c_per_last);
   assign w_quiet_done  = (r_quiet == c_qui_last);

   ad7266_sclk_gen #(
      .CLK_DIV    (CLK_DIV)
   ) u_sclk_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (w_run),
      .clear      (w_clear),
      .adc_sclk   (adc_sclk),
      .rise_pulse (w_rise),
      .edge_cnt   (w_edge_cnt)
   );

`ifdef AD7266_ZERO_CHECK_EN
   logic r_frame_err;
   logic w_pad_err;

   assign w_pad_err = pad_nonzero({r_sra[FRAME_BITS-1:DATA_MSB+1], r_sra[DATA_LSB-1:0]})
                    | pad_nonzero({r_srb[FRAME_BITS-1:DATA_MSB+1], r_srb[DATA_LSB-1:0]});

   // Padding check result, refreshed once per frame alongside the data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_err <= 1'b0;
      end else if (r_state == DONE) begin
         r_frame_err <= w_pad_err;
      end
   end

   assign dout.frame_err = r_frame_err;
`else
   // Padding bits are shifted through but only consumed by the zero check
   logic w_unused_pad;
   assign w_unused_pad = ^{r_sra[FRAME_BITS-1:DATA_MSB+1], r_sra[DATA_LSB-1:0],
                           r_srb[FRAME_BITS-1:DATA_MSB+1], r_srb[DATA_LSB-1:0]};
`endif

   // Frame sequencer: start, shift, deliver, then hold CS_n high until the
   // sample period and quiet time are both satisfied. A restart from IDLE
   // is immediate since QUIET already enforced the CS_n-high minimum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_cs_n   <= 1'b1;
         r_addr   <= 3'd0;
         r_busy   <= 1'b0;
         r_period <= '0;
         r_quiet  <= '0;
         r_sra    <= '0;
         r_srb    <= '0;
         r_dataa  <= '0;
         r_datab  <= '0;
         r_wren   <= 1'b0;
      end else begin
         r_wren <= 1'b0;
         // Saturating period count; cleared on each CS_n fall
         if (!w_period_done) begin
            r_period <= r_period + 1'b1;
         end
         case (r_state)
            IDLE: begin
               if (enable) begin
                  r_state  <= SHIFT;
                  r_cs_n   <= 1'b0;
                  r_addr   <= chsel;
                  r_busy   <= 1'b1;
                  r_period <= '0;
               end
            end
            SHIFT: begin
               if (w_rise) begin
                  r_sra <= {r_sra[FRAME_BITS-2:0], adc_douta};
                  r_srb <= {r_srb[FRAME_BITS-2:0], adc_doutb};
                  if (w_edge_cnt == c_last_edge) begin
                     r_state <= DONE;
                  end
               end
            end
            DONE: begin
               r_cs_n  <= 1'b1;
               r_dataa <= code_to_word(r_sra[DATA_MSB:DATA_LSB]);
               r_datab <= code_to_word(r_srb[DATA_MSB:DATA_LSB]);
               r_wren  <= 1'b1;
               r_quiet <= '0;
               r_state <= QUIET;
            end
            QUIET: begin
               if (!w_quiet_done) begin
                  r_quiet <= r_quiet + 1'b1;
               end else if (enable && w_period_done) begin
                  r_state  <= SHIFT;
                  r_cs_n   <= 1'b0;
                  r_addr   <= chsel;
                  r_period <= '0;
               end else if (!enable) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign adc_cs_n         = r_cs_n;
   assign adc_addr         = r_addr;
   assign busy             = r_busy;
   assign dout.ad7266dataa = r_dataa;
   assign dout.ad7266datab = r_datab;
   assign dout.ad7266wren  = r_wren;

endmodule
`default_nettype wire

// File: tb/tb_ad7266_rx.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : tb_ad7266_rx                                                  |
// | Desc     : Directed self-checking bench for ad7266_rx with a behavioural |
// |            AD7266 serial model. A second instance runs a short sample    |
// |            period. AD7266_ZERO_CHECK_EN enables the frame_err scenario.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ad7266_rx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       enable20 = 1'b0;
   logic [2:0] chsel = 3'd0;
   logic       adc_douta = 1'b0;
   logic       adc_doutb = 1'b0;
   logic       adc_cs_n;
   logic       adc_sclk;
   logic [2:0] adc_addr;
   logic       busy;
   logic       cs20;
   logic       sclk20;
   logic [2:0] addr20;
   logic       busy20;

   int checks = 0;
   int failures = 0;

   // 16-bit frame words the model serialises: {2'b0, code, 2'b0}
   logic [15:0] wa = 16'h0000;
   logic [15:0] wb = 16'h0000;
   int          fall_k = 0;

   // Results captured by watch_frame
   int          m_rises, m_low, m_cs_low, m_wren, m_r16, m_wcyc, m_first_fall;
   logic        m_timeout;
   logic [15:0] m_da, m_db;
   logic [2:0]  m_addr;
   logic        m_ferr;

   always #5 clk = ~clk;

   ad7266_rx_if dif ();
   ad7266_rx_if dif20 ();

   ad7266_rx dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .chsel     (chsel),
      .adc_douta (adc_douta),
      .adc_doutb (adc_doutb),
      .adc_cs_n  (adc_cs_n),
      .adc_sclk  (adc_sclk),
      .adc_addr  (adc_addr),
      .busy      (busy),
      .dout      (dif)
   );

   ad7266_rx #(
      .SAMPLE_PERIOD (20)
   ) dut20 (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable20),
      .chsel     (3'd0),
      .adc_douta (1'b0),
      .adc_doutb (1'b0),
      .adc_cs_n  (cs20),
      .adc_sclk  (sclk20),
      .adc_addr  (addr20),
      .busy      (busy20),
      .dout      (dif20)
   );

   // ADC model: bit 16-k of each word appears after SCLK fall k
   always @(negedge adc_sclk or posedge adc_cs_n) begin
      if (adc_cs_n) begin
         fall_k = 0;
      end else if (fall_k < 16) begin
         fall_k = fall_k + 1;
         adc_douta = wa[16 - fall_k];
         adc_doutb = wb[16 - fall_k];
      end
   end

   // Samples one frame of dut on falling clk edges; cycle 0 is the first CS_n-low sample
   task automatic watch_frame();
      int   n;
      logic prev;
      m_rises = 0; m_low = 0; m_cs_low = 0; m_wren = 0;
      m_r16 = -1; m_wcyc = -1; m_first_fall = -1; m_timeout = 1'b0;
      m_da = 16'hxxxx; m_db = 16'hxxxx; m_ferr = 1'bx;
      n = 0;
      while (adc_cs_n && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (adc_cs_n) begin
         m_timeout = 1'b1;
         return;
      end
      n = 0;
      prev = adc_sclk;
      while (n < 300) begin
         if (dif.ad7266wren) begin
            m_wren++;
            m_wcyc = n;
            m_da = dif.ad7266dataa;
            m_db = dif.ad7266datab;
`ifdef AD7266_ZERO_CHECK_EN
            m_ferr = dif.frame_err;
`endif
         end
         if (adc_cs_n) break;
         m_cs_low++;
         m_addr = adc_addr;
         if (!adc_sclk) begin
            m_low++;
            if (m_first_fall < 0) m_first_fall = n;
         end
         if (!prev && adc_sclk) begin
            m_rises++;
            if (m_rises == 16) m_r16 = n;
         end
         prev = adc_sclk;
         n++;
         @(negedge clk);
      end
      if (n >= 300) m_timeout = 1'b1;
   endtask

   task automatic test_reset();
      enable = 1'b1; chsel = 3'd3;
      wa = 16'h2AF0;   // 0x0ABC << 2
      wb = 16'h048C;   // 0x0123 << 2
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (adc_cs_n !== 1'b1) begin failures++; $display("FAIL rst_cs_n: got %b want 1", adc_cs_n); end
      checks++; if (adc_sclk !== 1'b1) begin failures++; $display("FAIL rst_sclk: got %b want 1", adc_sclk); end
      checks++; if (dif.ad7266wren !== 1'b0) begin failures++; $display("FAIL rst_wren: got %b want 0", dif.ad7266wren); end
      checks++; if (dif.ad7266dataa !== 16'h0 || dif.ad7266datab !== 16'h0) begin
         failures++; $display("FAIL rst_data: got %h/%h want 0000/0000", dif.ad7266dataa, dif.ad7266datab); end
      checks++; if (busy !== 1'b0 || adc_addr !== 3'd0) begin
         failures++; $display("FAIL rst_busy_addr: got %b/%0d want 0/0", busy, adc_addr); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (adc_cs_n !== 1'b0 || busy !== 1'b1) begin
         failures++; $display("FAIL first_cs_fall: cs_n=%b busy=%b want 0/1", adc_cs_n, busy); end
      checks++; if (adc_addr !== 3'd3) begin failures++; $display("FAIL first_addr: got %0d want 3", adc_addr); end
      watch_frame();
      checks++; if (m_timeout !== 1'b0) begin failures++; $display("FAIL frame1_timeout: got %b want 0", m_timeout); end
      checks++; if (m_rises !== 16) begin failures++; $display("FAIL frame1_rises: got %0d want 16", m_rises); end
      checks++; if (m_low !== 32) begin failures++; $display("FAIL frame1_sclk_low: got %0d want 32", m_low); end
      checks++; if (m_first_fall !== 2) begin failures++; $display("FAIL frame1_first_fall: got %0d want 2", m_first_fall); end
      checks++; if (m_cs_low !== 65) begin failures++; $display("FAIL frame1_cs_low: got %0d want 65", m_cs_low); end
      checks++; if (m_wren !== 1) begin failures++; $display("FAIL frame1_wren_count: got %0d want 1", m_wren); end
      checks++; if (m_wcyc - m_r16 !== 1) begin failures++; $display("FAIL frame1_latency: got %0d want 1", m_wcyc - m_r16); end
      checks++; if (m_da !== 16'h0ABC) begin failures++; $display("FAIL frame1_dataa: got %h want 0abc", m_da); end
      checks++; if (m_db !== 16'h0123) begin failures++; $display("FAIL frame1_datab: got %h want 0123", m_db); end
   endtask

   task automatic test_data_and_chsel();
      int n;
      wa = 16'h1554;   // 0x0555 << 2
      wb = 16'h2AA8;   // 0x0AAA << 2
      chsel = 3'd5;
      n = 0;
      while (adc_cs_n && n < 200) begin @(negedge clk); n++; end
      chsel = 3'd2;
      watch_frame();
      checks++; if (m_addr !== 3'd5) begin failures++; $display("FAIL chsel_hold: got %0d want 5", m_addr); end
      checks++; if (m_wren !== 1) begin failures++; $display("FAIL data2_wren_count: got %0d want 1", m_wren); end
      checks++; if (m_da !== 16'h0555 || m_db !== 16'h0AAA) begin
         failures++; $display("FAIL data2_words: got %h/%h want 0555/0aaa", m_da, m_db); end
      repeat (5) @(negedge clk);
      checks++; if (dif.ad7266dataa !== 16'h0555 || dif.ad7266datab !== 16'h0AAA || dif.ad7266wren !== 1'b0) begin
         failures++; $display("FAIL data_hold: got %h/%h wren=%b want 0555/0aaa wren=0",
                              dif.ad7266dataa, dif.ad7266datab, dif.ad7266wren); end
   endtask

   task automatic test_period();
      int   t[10];
      int   t20[10];
      int   c, c20, cyc, dbl;
      logic pcs, pcs20, pwren;
      enable20 = 1'b1;
      c = 0; c20 = 0; cyc = 0; dbl = 0;
      pcs = adc_cs_n; pcs20 = cs20; pwren = dif.ad7266wren;
      while ((c < 10 || c20 < 10) && cyc < 1200) begin
         @(negedge clk);
         cyc++;
         if (pcs && !adc_cs_n && c < 10) begin t[c] = cyc; c++; end
         if (pcs20 && !cs20 && c20 < 10) begin t20[c20] = cyc; c20++; end
         if (pwren && dif.ad7266wren) dbl++;
         pcs = adc_cs_n; pcs20 = cs20; pwren = dif.ad7266wren;
      end
      enable20 = 1'b0;
      checks++; if (c !== 10 || c20 !== 10) begin failures++; $display("FAIL period_count: got %0d/%0d want 10/10", c, c20); end
      for (int i = 1; i < c; i++) begin
         checks++; if (t[i] - t[i-1] !== 80) begin
            failures++; $display("FAIL period80_%0d: got %0d want 80", i, t[i] - t[i-1]); end
      end
      for (int i = 1; i < c20; i++) begin
         checks++; if (t20[i] - t20[i-1] !== 69) begin
            failures++; $display("FAIL period20_%0d: got %0d want 69", i, t20[i] - t20[i-1]); end
      end
      checks++; if (dbl !== 0) begin failures++; $display("FAIL wren_back_to_back: got %0d want 0", dbl); end
   endtask

   task automatic test_enable_drop();
      int   n, r, act, wr;
      logic prev;
      n = 0;
      while (!adc_cs_n && n < 200) begin @(negedge clk); n++; end
      wa = 16'h3C3C;   // 0x0F0F << 2
      wb = 16'h03C0;   // 0x00F0 << 2
      n = 0;
      while (adc_cs_n && n < 200) begin @(negedge clk); n++; end
      r = 0; prev = adc_sclk; n = 0;
      while (r < 5 && n < 200) begin
         @(negedge clk); n++;
         if (!prev && adc_sclk) r++;
         prev = adc_sclk;
      end
      enable = 1'b0;
      watch_frame();
      checks++; if (m_rises !== 11) begin failures++; $display("FAIL drop_rest_rises: got %0d want 11", m_rises); end
      checks++; if (m_wren !== 1) begin failures++; $display("FAIL drop_wren_count: got %0d want 1", m_wren); end
      checks++; if (m_da !== 16'h0F0F || m_db !== 16'h00F0) begin
         failures++; $display("FAIL drop_words: got %h/%h want 0f0f/00f0", m_da, m_db); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL drop_busy_quiet: got %b want 1", busy); end
      repeat (10) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drop_busy_idle: got %b want 0", busy); end
      act = 0; wr = 0;
      repeat (200) begin
         @(negedge clk);
         if (!adc_cs_n) act++;
         if (dif.ad7266wren) wr++;
      end
      checks++; if (act !== 0 || wr !== 0) begin
         failures++; $display("FAIL drop_idle_activity: cs_low=%0d wren=%0d want 0/0", act, wr); end
   endtask

   task automatic test_reset_mid_frame();
      int   n, r, wr;
      logic prev;
      wa = 16'h3FFC;   // 0x0FFF << 2
      wb = 16'h0004;   // 0x0001 << 2
      chsel = 3'd1;
      enable = 1'b1;
      n = 0;
      while (adc_cs_n && n < 200) begin @(negedge clk); n++; end
      r = 0; prev = adc_sclk; n = 0;
      while (r < 8 && n < 200) begin
         @(negedge clk); n++;
         if (!prev && adc_sclk) r++;
         prev = adc_sclk;
      end
      rst_n = 1'b0;
      #1;
      checks++; if (adc_cs_n !== 1'b1 || adc_sclk !== 1'b1) begin
         failures++; $display("FAIL midrst_pins: cs_n=%b sclk=%b want 1/1", adc_cs_n, adc_sclk); end
      checks++; if (dif.ad7266dataa !== 16'h0 || dif.ad7266datab !== 16'h0 || busy !== 1'b0) begin
         failures++; $display("FAIL midrst_outputs: got %h/%h busy=%b want 0000/0000 busy=0",
                              dif.ad7266dataa, dif.ad7266datab, busy); end
      wr = 0;
      repeat (3) begin
         @(negedge clk);
         if (dif.ad7266wren) wr++;
      end
      checks++; if (wr !== 0) begin failures++; $display("FAIL midrst_wren: got %0d want 0", wr); end
      rst_n = 1'b1;
      watch_frame();
      checks++; if (m_rises !== 16 || m_first_fall !== 2) begin
         failures++; $display("FAIL post_rst_frame: rises=%0d first_fall=%0d want 16/2", m_rises, m_first_fall); end
      checks++; if (m_wren !== 1) begin failures++; $display("FAIL post_rst_wren: got %0d want 1", m_wren); end
      checks++; if (m_da !== 16'h0FFF || m_db !== 16'h0001) begin
         failures++; $display("FAIL post_rst_words: got %h/%h want 0fff/0001", m_da, m_db); end
   endtask

`ifdef AD7266_ZERO_CHECK_EN
   task automatic test_zero_check();
      wa = 16'hAAF0;   // leading bit forced high, code 0x0ABC
      wb = 16'h048C;
      watch_frame();
      checks++; if (m_ferr !== 1'b1) begin failures++; $display("FAIL zc_err_set: got %b want 1", m_ferr); end
      checks++; if (m_da !== 16'h0ABC || m_wren !== 1) begin
         failures++; $display("FAIL zc_data: got %h wren=%0d want 0abc/1", m_da, m_wren); end
      wa = 16'h2AF0;
      watch_frame();
      checks++; if (m_ferr !== 1'b0) begin failures++; $display("FAIL zc_err_clear: got %b want 0", m_ferr); end
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, limit 1000000 ns");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_data_and_chsel();
      test_period();
      test_enable_drop();
      test_reset_mid_frame();
`ifdef AD7266_ZERO_CHECK_EN
      test_zero_check();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
